// File: rtl/param_shift_pkg.sv
// Shared mode codes, FSM state encoding and mode classification for the burst shift register.
// No logic of its own; imported by the register top and its step unit.
package param_shift_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True for the modes that consume the step count.
    function automatic logic is_step_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// One-step next value of the register for a given mode; purely combinational, zero latency.
// No flow control: non-step modes pass q_i through unchanged.
module shift_step_unit
    import param_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              sin_l_i,
    input  logic              sin_r_i,
    output logic [WIDTH-1:0]  step_o
);

    always_comb begin
        step_o = q_i;
        case (mode_i)
            MODE_SHR: step_o = {sin_l_i, q_i[WIDTH-1:1]};
            MODE_SHL: step_o = {q_i[WIDTH-2:0], sin_r_i};
            MODE_ROR: step_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ROL: step_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ASR: step_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default:  step_o = q_i;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// Shift/rotate/load register with N-step bursts; first step on the accepting edge, done one cycle after the last.
// No backpressure: start is only honoured in IDLE, requests while busy are dropped.
module param_shift_register
    import param_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [CNT_W-1:0]  amount,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               done_q, done_d;
    logic [MODE_W-1:0]  step_mode;
    logic [WIDTH-1:0]   step_val;

    // The accepting edge already steps, so the unit sees the live mode in IDLE.
    assign step_mode = (state_q == ST_SHIFT) ? mode_q : mode;

    shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i     (q_q),
        .mode_i  (step_mode),
        .sin_l_i (sin_l),
        .sin_r_i (sin_r),
        .step_o  (step_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_LOAD) begin
                        q_d    = d;
                        done_d = 1'b1;
                    end else if (is_step_mode(mode) && (amount != '0)) begin
                        q_d    = step_val;
                        mode_d = mode;
                        cnt_d  = amount - CNT_W'(1);
                        if (amount != CNT_W'(1)) begin
                            state_d = ST_SHIFT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                q_d   = step_val;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = (state_q == ST_SHIFT);
    assign done   = done_q;

endmodule
